// File: rtl/f2h_axi_req_arbiter.sv
// f2h_axi_req_arbiter: round-robin sharing of the HPS F2H AXI3 slave port, one single-beat access at a time
module f2h_axi_req_arbiter #(
  parameter int         NUM_REQ     = 2,
  parameter logic [7:0] AXI_ID_BASE = 8'h00,
  parameter logic [3:0] AXCACHE     = 4'h0,
  parameter logic [2:0] AXPROT      = 3'h0,
  parameter logic [4:0] AXUSER      = 5'h00
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0]  req_wstrb,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [7:0]            axi_awid,
  output logic [31:0]           axi_awaddr,
  output logic [3:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  output logic [1:0]            axi_awlock,
  output logic [3:0]            axi_awcache,
  output logic [2:0]            axi_awprot,
  output logic [4:0]            axi_awuser,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [7:0]            axi_wid,
  output logic [31:0]           axi_wdata,
  output logic [3:0]            axi_wstrb,
  output logic                  axi_wlast,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [7:0]            axi_bid,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [7:0]            axi_arid,
  output logic [31:0]           axi_araddr,
  output logic [3:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  output logic [1:0]            axi_arlock,
  output logic [3:0]            axi_arcache,
  output logic [2:0]            axi_arprot,
  output logic [4:0]            axi_aruser,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [7:0]            axi_rid,
  input  logic [31:0]           axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  input  logic                  axi_rvalid,
  output logic                  axi_rready
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;
  state_t state, next_state;
  logic [IW-1:0] ptr, pick, idx;
  logic found, aw_done, w_done;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] wstrb_q;
  logic [7:0] id;
  assign id = AXI_ID_BASE | 8'(ptr);
  assign axi_awid = id;
  assign axi_wid = id;
  assign axi_arid = id;
  assign axi_awaddr = addr_q;
  assign axi_araddr = addr_q;
  assign axi_wdata = wdata_q;
  assign axi_wstrb = wstrb_q;
  assign axi_wlast = 1'b1;
  assign axi_awlen = 4'h0;
  assign axi_arlen = 4'h0;
  assign axi_awsize = 3'b010;
  assign axi_arsize = 3'b010;
  assign axi_awburst = 2'b01;
  assign axi_arburst = 2'b01;
  assign axi_awlock = 2'b00;
  assign axi_arlock = 2'b00;
  assign axi_awcache = AXCACHE;
  assign axi_arcache = AXCACHE;
  assign axi_awprot = AXPROT;
  assign axi_arprot = AXPROT;
  assign axi_awuser = AXUSER;
  assign axi_aruser = AXUSER;
  // round-robin search from ptr+1; scanning downward lets the nearest requester win
  always_comb begin
    pick = '0;
    idx = '0;
    found = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IW'((int'(ptr) + i) % NUM_REQ);
      if (req_valid[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  // next state and handshake outputs, all decoded from the current state
  always_comb begin
    next_state = state;
    req_ready = '0;
    rsp_valid = '0;
    axi_awvalid = 1'b0;
    axi_wvalid = 1'b0;
    axi_bready = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready = 1'b0;
    case (state)
      IDLE: if (found) begin
        req_ready = NUM_REQ'(1) << pick;
        next_state = req_write[pick] ? WR_AW_W : RD_AR;
      end
      WR_AW_W: begin
        axi_awvalid = !aw_done;
        axi_wvalid = !w_done;
        if ((aw_done || axi_awready) && (w_done || axi_wready)) next_state = WR_B;
      end
      WR_B: begin
        axi_bready = 1'b1;
        if (axi_bvalid) next_state = RSP;
      end
      RD_AR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) next_state = RD_R;
      end
      RD_R: begin
        axi_rready = 1'b1;
        if (axi_rvalid) next_state = RSP;
      end
      RSP: begin
        rsp_valid = NUM_REQ'(1) << ptr;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end
  // request latch, split AW/W tracking and response capture with ID/rlast checking
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ptr <= IW'(NUM_REQ - 1);
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= '0;
    end else begin
      if (state == IDLE && found) begin
        ptr <= pick;
        addr_q <= req_addr[pick*32 +: 32];
        wdata_q <= req_wdata[pick*32 +: 32];
        wstrb_q <= req_wstrb[pick*4 +: 4];
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (state == WR_AW_W) begin
        aw_done <= aw_done | axi_awready;
        w_done <= w_done | axi_wready;
      end
      if (state == WR_B && axi_bvalid) rsp_resp <= (axi_bid != id) ? 2'b10 : axi_bresp;
      if (state == RD_R && axi_rvalid) begin
        rsp_rdata <= axi_rdata;
        rsp_resp <= (axi_rid != id || !axi_rlast) ? 2'b10 : axi_rresp;
      end
    end
endmodule

// File: tb/tb_f2h_axi_req_arbiter.sv
// tb_f2h_axi_req_arbiter: directed scoreboard bench with a configurable-delay AXI3 slave model
module tb_f2h_axi_req_arbiter;
  localparam int N = 2;
  logic clk = 0, reset_n = 1;
  logic [N-1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid;
  logic [N*32-1:0] req_addr = '0, req_wdata = '0;
  logic [N*4-1:0] req_wstrb = '0;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [7:0] axi_awid, axi_wid, axi_arid, axi_bid = '0, axi_rid = '0;
  logic [31:0] axi_awaddr, axi_araddr, axi_wdata, axi_rdata = '0;
  logic [3:0] axi_awlen, axi_arlen, axi_awcache, axi_arcache, axi_wstrb;
  logic [2:0] axi_awsize, axi_arsize, axi_awprot, axi_arprot;
  logic [1:0] axi_awburst, axi_arburst, axi_awlock, axi_arlock, axi_bresp = '0, axi_rresp = '0;
  logic [4:0] axi_awuser, axi_aruser;
  logic axi_awvalid, axi_awready = 0, axi_wlast, axi_wvalid, axi_wready = 0;
  logic axi_bvalid = 0, axi_bready, axi_arvalid, axi_arready = 0;
  logic axi_rlast = 0, axi_rvalid = 0, axi_rready;

  f2h_axi_req_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache),
    .axi_awprot(axi_awprot), .axi_awuser(axi_awuser), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wid(axi_wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
    .axi_arprot(axi_arprot), .axi_aruser(axi_aruser), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    logic [1:0] resp;
    int lat;
  } txn_t;
  txn_t q_grant[$], q_aw[$], q_w[$], q_ar[$], q_rsp[$];

  int checks = 0, failures = 0;
  int cyc = 0, grant_cyc = 0, b_hs = 0;
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0;
  logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;
  bit bid_force = 0;
  logic [7:0] bid_val = '0, aw_id_cap = '0, ar_id_cap = '0;

  function automatic void chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (axi_bvalid && axi_bready) b_hs <= b_hs + 1;
  end

  initial forever begin
    @(negedge clk);
    if (axi_awvalid) begin
      axi_awready = (aw_n >= aw_dly);
      if (axi_awready) aw_id_cap = axi_awid;
      aw_n++;
    end else begin
      axi_awready = 0;
      aw_n = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (axi_wvalid) begin
      axi_wready = (w_n >= w_dly);
      w_n++;
    end else begin
      axi_wready = 0;
      w_n = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (axi_bready) begin
      axi_bvalid = (b_n >= b_dly);
      axi_bid = bid_force ? bid_val : aw_id_cap;
      axi_bresp = b_resp_cfg;
      b_n++;
    end else begin
      axi_bvalid = 0;
      b_n = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (axi_arvalid) begin
      axi_arready = (ar_n >= ar_dly);
      if (axi_arready) ar_id_cap = axi_arid;
      ar_n++;
    end else begin
      axi_arready = 0;
      ar_n = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (axi_rready) begin
      axi_rvalid = (r_n >= r_dly);
      axi_rid = ar_id_cap;
      axi_rdata = r_data_cfg;
      axi_rresp = r_resp_cfg;
      axi_rlast = 1;
      r_n++;
    end else begin
      axi_rvalid = 0;
      r_n = 0;
    end
  end

  initial forever begin
    txn_t t;
    @(negedge clk);
    #1;
    if (req_ready != 0) begin
      grant_cyc = cyc;
      if (q_grant.size() == 0) chk("grant_unexpected", req_ready, 0);
      else begin
        t = q_grant.pop_front();
        chk("grant", req_ready, N'(1) << t.idx);
      end
    end
    if (axi_awvalid && axi_awready) begin
      if (q_aw.size() == 0) chk("aw_unexpected", axi_awvalid, 0);
      else begin
        t = q_aw.pop_front();
        chk("awaddr", axi_awaddr, t.addr);
        chk("awid", axi_awid, 8'(t.idx));
        chk("aw_const", {axi_awlen, axi_awsize, axi_awburst, axi_awlock}, {4'h0, 3'b010, 2'b01, 2'b00});
      end
    end
    if (axi_wvalid && axi_wready) begin
      if (q_w.size() == 0) chk("w_unexpected", axi_wvalid, 0);
      else begin
        t = q_w.pop_front();
        chk("wdata", axi_wdata, t.data);
        chk("wstrb_wlast", {axi_wstrb, axi_wlast}, {t.strb, 1'b1});
      end
    end
    if (axi_arvalid && axi_arready) begin
      if (q_ar.size() == 0) chk("ar_unexpected", axi_arvalid, 0);
      else begin
        t = q_ar.pop_front();
        chk("araddr", axi_araddr, t.addr);
        chk("arid", axi_arid, 8'(t.idx));
      end
    end
    if (rsp_valid != 0) begin
      if (q_rsp.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        t = q_rsp.pop_front();
        chk("rsp_valid", rsp_valid, N'(1) << t.idx);
        chk("rsp_resp", rsp_resp, t.resp);
        if (!t.wr) chk("rsp_rdata", rsp_rdata, t.data);
        if (t.lat != 0) chk("rsp_latency", cyc - grant_cyc, t.lat);
      end
    end
  end

  task automatic push_txn(int idx, bit wr, logic [31:0] addr, logic [31:0] data,
                          logic [3:0] strb, logic [1:0] resp, int lat);
    txn_t t;
    t.idx = idx; t.wr = wr; t.addr = addr; t.data = data;
    t.strb = strb; t.resp = resp; t.lat = lat;
    q_grant.push_back(t);
    if (wr) begin
      q_aw.push_back(t);
      q_w.push_back(t);
    end else q_ar.push_back(t);
    q_rsp.push_back(t);
  endtask

  task automatic do_req(int idx, bit wr, logic [31:0] addr, logic [31:0] data,
                        logic [3:0] strb, logic [1:0] resp, int lat);
    int k = 0;
    push_txn(idx, wr, addr, data, strb, resp, lat);
    @(negedge clk);
    req_valid[idx] = 1;
    req_write[idx] = wr;
    req_addr[idx*32 +: 32] = addr;
    req_wdata[idx*32 +: 32] = wr ? data : 32'h0;
    req_wstrb[idx*4 +: 4] = strb;
    #1;
    while (!req_ready[idx] && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k == 200) chk("req_ready_timeout", req_ready, N'(1) << idx);
    @(negedge clk);
    req_valid[idx] = 0;
  endtask

  task automatic run_both(int n, int first);
    int cnt[N];
    int k = 0;
    for (int j = 0; j < 2 * n; j++) begin
      int i = (first + j) % N;
      push_txn(i, 1, 32'hFFC0_3000 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF, 2'b00, 3);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      req_valid[i] = 1;
      req_write[i] = 1;
      req_addr[i*32 +: 32] = 32'hFFC0_3000 + 32'(i * 4);
      req_wdata[i*32 +: 32] = 32'hA0 + 32'(i);
      req_wstrb[i*4 +: 4] = 4'hF;
    end
    while (req_valid != 0 && k < 400) begin
      #1;
      for (int i = 0; i < N; i++) if (req_ready[i]) cnt[i]++;
      @(negedge clk);
      for (int i = 0; i < N; i++) if (cnt[i] == n) req_valid[i] = 0;
      k++;
    end
    if (k == 400) chk("both_timeout", req_valid, 0);
  endtask

  task automatic wait_rsp();
    int k = 0;
    while (q_rsp.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (q_rsp.size() != 0) chk("rsp_timeout", q_rsp.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int b0, k;
    #1 reset_n = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", {req_ready, rsp_valid, rsp_rdata, rsp_resp, axi_awvalid, axi_wvalid,
                        axi_bready, axi_arvalid, axi_rready}, 0);
    @(negedge clk);
    reset_n = 1;
    repeat (2) @(negedge clk);

    do_req(0, 1, 32'hFFC0_2000, 32'h41, 4'h1, 2'b00, 3);
    wait_rsp();

    run_both(2, 1);
    wait_rsp();

    w_dly = 5;
    b0 = b_hs;
    do_req(0, 1, 32'hFFC0_2008, 32'h42, 4'h3, 2'b00, 0);
    @(negedge clk);
    #1;
    chk("split_aw_low", axi_awvalid, 0);
    chk("split_w_held", axi_wvalid, 1);
    wait_rsp();
    chk("single_b", b_hs - b0, 1);
    w_dly = 0;

    r_dly = 4;
    r_data_cfg = 32'h60;
    do_req(1, 0, 32'hFFC0_2014, 32'h60, 4'h0, 2'b00, 0);
    wait_rsp();
    r_dly = 0;

    bid_force = 1;
    bid_val = 8'h05;
    do_req(0, 1, 32'hFFC0_2000, 32'h55, 4'hF, 2'b10, 0);
    wait_rsp();
    bid_force = 0;

    r_resp_cfg = 2'b11;
    r_data_cfg = 32'h77;
    do_req(1, 0, 32'hFFC0_2018, 32'h77, 4'h0, 2'b11, 0);
    wait_rsp();
    r_resp_cfg = 2'b00;

    b_dly = 20;
    do_req(1, 1, 32'hFFC0_2020, 32'h99, 4'hF, 2'b00, 0);
    k = 0;
    while (!axi_bready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("reach_wr_b", axi_bready, 1);
    #2 reset_n = 0;
    #1;
    chk("async_reset", {req_ready, rsp_valid, rsp_rdata, rsp_resp, axi_awvalid, axi_wvalid,
                        axi_bready, axi_arvalid, axi_rready}, 0);
    q_grant.delete();
    q_aw.delete();
    q_w.delete();
    q_ar.delete();
    q_rsp.delete();
    b_dly = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (2) @(negedge clk);
    run_both(1, 0);
    wait_rsp();
    chk("queues_drained", q_grant.size() + q_aw.size() + q_w.size() + q_ar.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
